// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request/response bus between the MEM-stage sequencer and the data cache.
//   master : sequencer side (drives request, receives ready and response)
//   slave  : cache side
// Signals:
//   dcache_req_valid   request valid
//   dcache_req_ready   cache accepts the request
//   dcache_req_we      1 = store, 0 = load
//   dcache_req_addr    request address
//   dcache_req_wdata   store data
//   dcache_resp_valid  response / store ack, one-cycle pulse
//   dcache_resp_data   load data
interface mem_stage_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  dcache_req_valid;
  logic                  dcache_req_ready;
  logic                  dcache_req_we;
  logic [DATA_WIDTH-1:0] dcache_req_addr;
  logic [DATA_WIDTH-1:0] dcache_req_wdata;
  logic                  dcache_resp_valid;
  logic [DATA_WIDTH-1:0] dcache_resp_data;

  modport master (
    output dcache_req_valid,
    output dcache_req_we,
    output dcache_req_addr,
    output dcache_req_wdata,
    input  dcache_req_ready,
    input  dcache_resp_valid,
    input  dcache_resp_data
  );

  modport slave (
    input  dcache_req_valid,
    input  dcache_req_we,
    input  dcache_req_addr,
    input  dcache_req_wdata,
    output dcache_req_ready,
    output dcache_resp_valid,
    output dcache_resp_data
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer. Turns a load/store held in EX/MEM into a valid/ready data-cache
// request, stalls the upstream pipeline registers and bubbles MEM/WB while the access is
// in flight, and issues the PC redirect / front-end flush for taken branches.
// Ports:
//   clk, reset (async, active-low)
//   ex_mem_valid, mem_read, mem_write, branch, branch_decision, target, alu_res,
//   write_data          : EX/MEM register outputs
//   dcache              : data-cache bus (mem_stage_ctrl_if.master)
//   load_data, load_data_valid : registered load result
//   stall, mem_wb_bubble       : pipeline hold / bubble insertion
//   redirect_valid, redirect_pc, flush : taken-branch redirect
//   timeout_err         : sticky watchdog error
// Build option: define MEM_STAGE_CTRL_TIMEOUT_EN to compile in the request watchdog.
module mem_stage_ctrl #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch,
  input  logic                  branch_decision,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic [DATA_WIDTH-1:0] alu_res,
  input  logic [DATA_WIDTH-1:0] write_data,
  mem_stage_ctrl_if.master      dcache,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_data_valid,
  output logic                  stall,
  output logic                  mem_wb_bubble,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  ldv_q;

  logic mem_op, is_load, in_flight, resp_hit, wd_expire;

  assign mem_op    = ex_mem_valid & (mem_read | mem_write);
  // Read+write together is a store.
  assign is_load   = mem_read & ~mem_write;
  assign in_flight = (state_q == StReq) | (state_q == StWait);
  assign resp_hit  = dcache.dcache_resp_valid &
                     ((state_q == StWait) | ((state_q == StReq) & dcache.dcache_req_ready));

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wd_cnt_q;
  logic            timeout_err_q;

  // Fires on the last permitted in-flight cycle so DONE follows exactly TIMEOUT_CYCLES cycles.
  assign wd_expire   = in_flight & (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign wd_expire          = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      load_data_q   <= '0;
      ldv_q         <= 1'b0;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      ldv_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_op) state_q <= StReq;
        end
        StReq, StWait: begin
          if (resp_hit) begin
            state_q <= StDone;
            ldv_q   <= is_load;
            if (is_load) load_data_q <= dcache.dcache_resp_data;
          end else if (wd_expire) begin
            state_q     <= StDone;
            ldv_q       <= is_load;
            load_data_q <= '0;
          end else if ((state_q == StReq) && dcache.dcache_req_ready) begin
            state_q <= StWait;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
      if (state_q == StIdle) begin
        wd_cnt_q <= '0;
      end else if (in_flight) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (wd_expire && !resp_hit) timeout_err_q <= 1'b1;
`endif
    end
  end

  // Combinational outputs are gated by reset so everything reads 0 while it is held low.
  assign dcache.dcache_req_valid = reset & (state_q == StReq);
  assign dcache.dcache_req_we    = reset & mem_write;
  assign dcache.dcache_req_addr  = reset ? alu_res : '0;
  assign dcache.dcache_req_wdata = reset ? write_data : '0;

  assign load_data       = load_data_q;
  assign load_data_valid = ldv_q;

  // DONE does not stall, so EX/MEM advances at its end.
  assign stall         = reset & (((state_q == StIdle) & mem_op) | in_flight);
  assign mem_wb_bubble = stall;

  assign redirect_valid = reset & ex_mem_valid & branch & branch_decision & ~stall;
  assign flush          = redirect_valid;
  assign redirect_pc    = reset ? target : '0;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl: reset, load, delayed-ready store, same-cycle
// ready/response, taken branch, branch combined with a load, watchdog, reset mid-access.
module tb_mem_stage_ctrl;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_mem_valid, mem_read, mem_write, branch, branch_decision;
  logic [DW-1:0] target, alu_res, write_data;
  logic [DW-1:0] load_data, redirect_pc;
  logic          load_data_valid, stall, mem_wb_bubble, redirect_valid, flush, timeout_err;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  mem_stage_ctrl #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_mem_valid   (ex_mem_valid),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .branch         (branch),
    .branch_decision(branch_decision),
    .target         (target),
    .alu_res        (alu_res),
    .write_data     (write_data),
    .dcache         (bus.master),
    .load_data      (load_data),
    .load_data_valid(load_data_valid),
    .stall          (stall),
    .mem_wb_bubble  (mem_wb_bubble),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_mem_valid = 0; mem_read = 0; mem_write = 0; branch = 0; branch_decision = 0;
    target = '0; alu_res = '0; write_data = '0;
    bus.dcache_req_ready = 0; bus.dcache_resp_valid = 0; bus.dcache_resp_data = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    ex_mem_valid = 1; mem_read = 1; mem_write = 1; branch = 1; branch_decision = 1;
    target = 64'h2000; alu_res = 64'h1000; write_data = 64'h55;
    bus.dcache_req_ready = 1; bus.dcache_resp_valid = 1; bus.dcache_resp_data = 64'hFF;
    #1;
    repeat (2) begin
      checks++; if (bus.dcache_req_valid !== 1'b0) begin errors++;
        $display("FAIL rst_req_valid got %b want 0", bus.dcache_req_valid); end
      checks++; if (bus.dcache_req_we !== 1'b0) begin errors++;
        $display("FAIL rst_req_we got %b want 0", bus.dcache_req_we); end
      checks++; if (bus.dcache_req_addr !== '0) begin errors++;
        $display("FAIL rst_req_addr got %h want 0", bus.dcache_req_addr); end
      checks++; if (bus.dcache_req_wdata !== '0) begin errors++;
        $display("FAIL rst_req_wdata got %h want 0", bus.dcache_req_wdata); end
      checks++; if (load_data !== '0 || load_data_valid !== 1'b0) begin errors++;
        $display("FAIL rst_load got %h/%b want 0/0", load_data, load_data_valid); end
      checks++; if (stall !== 1'b0 || mem_wb_bubble !== 1'b0) begin errors++;
        $display("FAIL rst_stall got %b/%b want 0/0", stall, mem_wb_bubble); end
      checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++;
        $display("FAIL rst_redirect got %b/%b want 0/0", redirect_valid, flush); end
      checks++; if (redirect_pc !== '0 || timeout_err !== 1'b0) begin errors++;
        $display("FAIL rst_pc_terr got %h/%b want 0/0", redirect_pc, timeout_err); end
      step();
    end
    clear_inputs();
    reset = 1;
    step();
  endtask

  task automatic test_load();
    ex_mem_valid = 1; mem_read = 1; alu_res = 64'h1000; bus.dcache_req_ready = 1;
    #1;
    checks++; if (stall !== 1'b1 || bus.dcache_req_valid !== 1'b0) begin errors++;
      $display("FAIL load_idle stall/req got %b/%b want 1/0", stall, bus.dcache_req_valid); end
    step(); // REQ
    checks++; if (bus.dcache_req_valid !== 1'b1 || stall !== 1'b1) begin errors++;
      $display("FAIL load_req req/stall got %b/%b want 1/1", bus.dcache_req_valid, stall); end
    checks++; if (bus.dcache_req_addr !== 64'h1000 || bus.dcache_req_we !== 1'b0) begin
      errors++;
      $display("FAIL load_req addr/we got %h/%b want 1000/0", bus.dcache_req_addr,
               bus.dcache_req_we); end
    step(); // WAIT
    bus.dcache_req_ready = 0; bus.dcache_resp_valid = 1; bus.dcache_resp_data = 64'hDEADBEEF;
    #1;
    checks++; if (stall !== 1'b1 || bus.dcache_req_valid !== 1'b0) begin errors++;
      $display("FAIL load_wait stall/req got %b/%b want 1/0", stall, bus.dcache_req_valid); end
    checks++; if (mem_wb_bubble !== 1'b1) begin errors++;
      $display("FAIL load_wait bubble got %b want 1", mem_wb_bubble); end
    step(); // DONE
    bus.dcache_resp_valid = 0;
    #1;
    checks++; if (stall !== 1'b0 || load_data_valid !== 1'b1) begin errors++;
      $display("FAIL load_done stall/ldv got %b/%b want 0/1", stall, load_data_valid); end
    checks++; if (load_data !== 64'hDEADBEEF) begin errors++;
      $display("FAIL load_done data got %h want deadbeef", load_data); end
    ex_mem_valid = 0; mem_read = 0;
    step(); // IDLE
    checks++; if (load_data_valid !== 1'b0 || load_data !== 64'hDEADBEEF) begin errors++;
      $display("FAIL load_after ldv/data got %b/%h want 0/deadbeef", load_data_valid,
               load_data); end
  endtask

  task automatic test_store_delayed();
    ex_mem_valid = 1; mem_write = 1; alu_res = 64'h3000; write_data = 64'h55;
    #1;
    checks++; if (stall !== 1'b1) begin errors++;
      $display("FAIL st_idle stall got %b want 1", stall); end
    step(); // REQ
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.dcache_req_valid !== 1'b1 || bus.dcache_req_we !== 1'b1) begin
        errors++;
        $display("FAIL st_hold%0d req/we got %b/%b want 1/1", i, bus.dcache_req_valid,
                 bus.dcache_req_we); end
      checks++; if (bus.dcache_req_addr !== 64'h3000 || bus.dcache_req_wdata !== 64'h55) begin
        errors++;
        $display("FAIL st_hold%0d addr/wdata got %h/%h want 3000/55", i, bus.dcache_req_addr,
                 bus.dcache_req_wdata); end
      step();
    end
    bus.dcache_req_ready = 1;
    #1;
    checks++; if (bus.dcache_req_valid !== 1'b1) begin errors++;
      $display("FAIL st_accept req got %b want 1", bus.dcache_req_valid); end
    step(); // WAIT
    bus.dcache_req_ready = 0; bus.dcache_resp_valid = 1; bus.dcache_resp_data = 64'hBAD;
    #1;
    checks++; if (bus.dcache_req_valid !== 1'b0 || stall !== 1'b1) begin errors++;
      $display("FAIL st_wait req/stall got %b/%b want 0/1", bus.dcache_req_valid, stall); end
    step(); // DONE
    bus.dcache_resp_valid = 0;
    #1;
    checks++; if (load_data_valid !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL st_done ldv/stall got %b/%b want 0/0", load_data_valid, stall); end
    checks++; if (load_data !== 64'hDEADBEEF) begin errors++;
      $display("FAIL st_done data got %h want deadbeef", load_data); end
    ex_mem_valid = 0; mem_write = 0;
    step();
  endtask

  task automatic test_same_cycle();
    // Response held high from IDLE on: the IDLE copy must be ignored.
    ex_mem_valid = 1; mem_read = 1; alu_res = 64'h1008;
    bus.dcache_req_ready = 1; bus.dcache_resp_valid = 1; bus.dcache_resp_data = 64'h12345678;
    #1;
    checks++; if (stall !== 1'b1) begin errors++;
      $display("FAIL sc_idle stall got %b want 1", stall); end
    step(); // REQ
    checks++; if (stall !== 1'b1 || load_data !== 64'hDEADBEEF) begin errors++;
      $display("FAIL sc_req stall/data got %b/%h want 1/deadbeef", stall, load_data); end
    step(); // DONE
    checks++; if (stall !== 1'b0 || load_data_valid !== 1'b1) begin errors++;
      $display("FAIL sc_done stall/ldv got %b/%b want 0/1", stall, load_data_valid); end
    checks++; if (load_data !== 64'h12345678) begin errors++;
      $display("FAIL sc_done data got %h want 12345678", load_data); end
    clear_inputs();
    step();
  endtask

  task automatic test_branch();
    ex_mem_valid = 1; branch = 1; branch_decision = 1; target = 64'h2000;
    #1;
    checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1) begin errors++;
      $display("FAIL br_taken rv/flush got %b/%b want 1/1", redirect_valid, flush); end
    checks++; if (redirect_pc !== 64'h2000 || stall !== 1'b0) begin errors++;
      $display("FAIL br_taken pc/stall got %h/%b want 2000/0", redirect_pc, stall); end
    branch_decision = 0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL br_not_taken rv/flush got %b/%b want 0/0", redirect_valid, flush); end
    clear_inputs();
    step();
  endtask

  task automatic test_branch_mem();
    ex_mem_valid = 1; branch = 1; branch_decision = 1; target = 64'h4000;
    mem_read = 1; alu_res = 64'h1010;
    bus.dcache_req_ready = 1; bus.dcache_resp_valid = 1; bus.dcache_resp_data = 64'hCAFE;
    #1;
    checks++; if (redirect_valid !== 1'b0 || stall !== 1'b1) begin errors++;
      $display("FAIL bm_idle rv/stall got %b/%b want 0/1", redirect_valid, stall); end
    step(); // REQ
    checks++; if (redirect_valid !== 1'b0) begin errors++;
      $display("FAIL bm_req rv got %b want 0", redirect_valid); end
    step(); // DONE
    checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1) begin errors++;
      $display("FAIL bm_done rv/flush got %b/%b want 1/1", redirect_valid, flush); end
    checks++; if (redirect_pc !== 64'h4000 || load_data !== 64'hCAFE) begin errors++;
      $display("FAIL bm_done pc/data got %h/%h want 4000/cafe", redirect_pc, load_data); end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    int n;
    ex_mem_valid = 1; mem_read = 1; alu_res = 64'h1018;
    #1;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    n = 0;
    while (stall === 1'b1 && n < 30) begin
      n++;
      step();
    end
    // One IDLE detection cycle plus eight watchdog cycles in REQ.
    checks++; if (n != 9) begin errors++;
      $display("FAIL to_stall_cycles got %0d want 9", n); end
    checks++; if (timeout_err !== 1'b1 || load_data !== '0) begin errors++;
      $display("FAIL to_done terr/data got %b/%h want 1/0", timeout_err, load_data); end
    clear_inputs();
    repeat (3) step();
    checks++; if (timeout_err !== 1'b1 || stall !== 1'b0) begin errors++;
      $display("FAIL to_sticky terr/stall got %b/%b want 1/0", timeout_err, stall); end
`else
    n = 20;
    repeat (n) step();
    checks++; if (stall !== 1'b1 || bus.dcache_req_valid !== 1'b1) begin errors++;
      $display("FAIL nowd_hold stall/req got %b/%b want 1/1", stall, bus.dcache_req_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL nowd_terr got %b want 0", timeout_err); end
    bus.dcache_req_ready = 1; bus.dcache_resp_valid = 1; bus.dcache_resp_data = 64'h77;
    step(); // DONE
    checks++; if (load_data !== 64'h77 || stall !== 1'b0) begin errors++;
      $display("FAIL nowd_done data/stall got %h/%b want 77/0", load_data, stall); end
    clear_inputs();
    step();
`endif
  endtask

  task automatic test_reset_mid();
    ex_mem_valid = 1; mem_read = 1; alu_res = 64'h1020; bus.dcache_req_ready = 1;
    #1;
    step(); // REQ
    step(); // WAIT
    bus.dcache_req_ready = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++;
      $display("FAIL rm_wait stall got %b want 1", stall); end
    #2;
    reset = 0;
    #1;
    checks++; if (bus.dcache_req_valid !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL rm_async req/stall got %b/%b want 0/0", bus.dcache_req_valid, stall); end
    checks++; if (bus.dcache_req_addr !== '0 || load_data !== '0) begin errors++;
      $display("FAIL rm_async addr/data got %h/%h want 0/0", bus.dcache_req_addr,
               load_data); end
    checks++; if (timeout_err !== 1'b0 || mem_wb_bubble !== 1'b0) begin errors++;
      $display("FAIL rm_async terr/bubble got %b/%b want 0/0", timeout_err, mem_wb_bubble); end
    clear_inputs();
    step();
    reset = 1;
    bus.dcache_resp_valid = 1; bus.dcache_resp_data = 64'hFFFF;
    step();
    bus.dcache_resp_valid = 0;
    step();
    checks++; if (load_data !== '0 || load_data_valid !== 1'b0) begin errors++;
      $display("FAIL rm_stray data/ldv got %h/%b want 0/0", load_data, load_data_valid); end
    checks++; if (stall !== 1'b0 || bus.dcache_req_valid !== 1'b0) begin errors++;
      $display("FAIL rm_stray stall/req got %b/%b want 0/0", stall, bus.dcache_req_valid); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load();
    test_store_delayed();
    test_same_cycle();
    test_branch();
    test_branch_mem();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
